// File: rtl/sram_ctrl_pkg.sv
// Shared types and default timing for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned CNT_W            = 4;
    localparam int unsigned DEF_ADDR_W       = 16;
    localparam int unsigned DEF_DATA_W       = 16;
    localparam int unsigned DEF_WR_PULSE_CYC = 1;
    localparam int unsigned DEF_RD_WAIT_CYC  = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_PULSE  = 3'd2,
        WR_HOLD   = 3'd3,
        RD_ACCESS = 3'd4,
        RD_TURN   = 3'd5
    } state_e;

    function automatic logic is_wr_state(state_e s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one request at a time, registered strobes.
// Optional write-verify read-back is enabled with macro SRAM_CTRL_READBACK_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned WR_PULSE_CYC = DEF_WR_PULSE_CYC,
    parameter int unsigned RD_WAIT_CYC  = DEF_RD_WAIT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
`ifdef SRAM_CTRL_READBACK_EN
    output logic              wr_err,
`endif
    output logic              cs_n,
    output logic              we_n,
    output logic              oe_n,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_io
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cs_n_q, cs_n_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic                drv_q, drv_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                wr_done_q, wr_done_d;
`ifdef SRAM_CTRL_READBACK_EN
    logic                wr_err_q, wr_err_d;
`endif

    // Next-state, datapath and strobe decode; strobes are derived from the next state
    // so the registered pins line up exactly with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        wr_done_d   = 1'b0;
`ifdef SRAM_CTRL_READBACK_EN
        wr_err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        state_d = WR_SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = RD_ACCESS;
                        cnt_d   = CNT_W'(RD_WAIT_CYC - 1);
                    end
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_W'(WR_PULSE_CYC - 1);
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
`ifdef SRAM_CTRL_READBACK_EN
                state_d = RD_ACCESS;
                cnt_d   = CNT_W'(RD_WAIT_CYC - 1);
`else
                state_d   = IDLE;
                cnt_d     = '0;
                wr_done_d = 1'b1;
`endif
            end
            RD_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = RD_TURN;
                    cnt_d       = '0;
                    rsp_valid_d = !we_q;
`ifdef SRAM_CTRL_READBACK_EN
                    // Verify reads report through wr_done/wr_err and leave rsp_rdata alone.
                    if (we_q) begin
                        wr_done_d = 1'b1;
                        wr_err_d  = (sram_io != wdata_q);
                    end else begin
                        rdata_d = sram_io;
                    end
`else
                    rdata_d = sram_io;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_n_d  = !(is_wr_state(state_d) || (state_d == RD_ACCESS));
        we_n_d  = (state_d != WR_PULSE);
        oe_n_d  = (state_d != RD_ACCESS);
        drv_d   = is_wr_state(state_d);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            drv_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
`ifdef SRAM_CTRL_READBACK_EN
            wr_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            drv_q       <= drv_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            wr_done_q   <= wr_done_d;
`ifdef SRAM_CTRL_READBACK_EN
            wr_err_q    <= wr_err_d;
`endif
        end
    end

    // Driver enable is registered alongside oe_n and never overlaps a read state.
    assign sram_io   = drv_q ? wdata_q : {DATA_W{1'bz}};

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign wr_done   = wr_done_q;
`ifdef SRAM_CTRL_READBACK_EN
    assign wr_err    = wr_err_q;
`endif
    assign cs_n      = cs_n_q;
    assign we_n      = we_n_q;
    assign oe_n      = oe_n_q;
    assign sram_addr = addr_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a scoreboard and a simple SRAM model.
// Define SRAM_CTRL_READBACK_EN to exercise the verify path against a stuck-at-0 bit 0.
module tb_sram_ctrl;

    localparam int unsigned WRP = 1;
    localparam int unsigned RDW = 2;
`ifdef SRAM_CTRL_READBACK_EN
    localparam bit          RB   = 1'b1;
    localparam logic [15:0] MASK = 16'hFFFE;
`else
    localparam bit          RB   = 1'b0;
    localparam logic [15:0] MASK = 16'hFFFF;
`endif
    // Cycles spent outside IDLE for a write, and offset from accept to the write strobe.
    localparam int unsigned W_LEN  = RB ? (WRP + 2 + RDW + 1) : (WRP + 2);
    localparam int unsigned WD_OFS = RB ? (WRP + 2 + RDW) : (WRP + 2);

    typedef struct {
        logic        is_wr;
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        wr_done;
`ifdef SRAM_CTRL_READBACK_EN
    logic        wr_err;
`endif
    logic        cs_n;
    logic        we_n;
    logic        oe_n;
    logic [15:0] sram_addr;
    wire  [15:0] sram_io;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    exp_t        exp_q[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] mem     [0:255];
    logic [15:0] cur_addr  = '0;
    logic [15:0] cur_wdata = '0;

    sram_ctrl #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .WR_PULSE_CYC (WRP),
        .RD_WAIT_CYC  (RDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .wr_done   (wr_done),
`ifdef SRAM_CTRL_READBACK_EN
        .wr_err    (wr_err),
`endif
        .cs_n      (cs_n),
        .we_n      (we_n),
        .oe_n      (oe_n),
        .sram_addr (sram_addr),
        .sram_io   (sram_io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model; it parks the bus at 0 while deselected so a stray controller drive shows up.
    logic        mdl_en;
    logic [15:0] mdl_val;
    assign mdl_en  = cs_n | ~oe_n;
    assign mdl_val = cs_n ? 16'h0000 : mem[sram_addr[7:0]];
    assign sram_io = mdl_en ? mdl_val : 16'hzzzz;

    always @(posedge we_n) begin
        if (cs_n == 1'b0) mem[sram_addr[7:0]] <= sram_io & MASK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on strobes plus per-cycle bus and address checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid || wr_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, rsp_valid, wr_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {30'd0, rsp_valid, wr_done}, e.is_wr ? 32'd1 : 32'd2);
                    chk("strobe_cycle", cyc, e.due);
                    if (!e.is_wr) chk("rsp_rdata", rsp_rdata, e.data);
`ifdef SRAM_CTRL_READBACK_EN
                    if (e.is_wr) chk("wr_err", wr_err, e.err);
`endif
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                e = exp_q.pop_front();
                chk("missed_strobe", cyc, e.due);
            end
`ifdef SRAM_CTRL_READBACK_EN
            if (!wr_done) chk("wr_err_idle", wr_err, 0);
`endif
            chk("we_oe_overlap", {30'd0, we_n, oe_n} == 32'd0, 0);
            if (cs_n) begin
                chk("bus_released", sram_io, 16'h0000);
            end else begin
                chk("sram_addr", sram_addr, cur_addr);
                if (oe_n) chk("bus_wdata", sram_io, cur_wdata);
                else      chk("bus_rdata", sram_io, ref_mem[sram_addr[7:0]]);
            end
        end
    end

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input bit keep, input bit expect_done, output int waited);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = we ? d : 16'hFFFF;
        waited    = 0;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("accept_timeout", req_ready, 1);
        cur_addr = a;
        if (we) cur_wdata = d;
        if (we && expect_done) ref_mem[a[7:0]] = d & MASK;
        e.is_wr = we;
        e.data  = ref_mem[a[7:0]];
        e.err   = ((d & MASK) != d);
        e.due   = cyc + 1 + (we ? int'(WD_OFS) : int'(RDW));
        if (expect_done) exp_q.push_back(e);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int          w;
        logic [15:0] a;
        logic [15:0] d;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_bus", sram_io, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write with a cycle-by-cycle strobe trace
        issue(1'b1, 16'h0010, 16'hA5C3, 1'b0, 1'b1, w);
        for (int k = 1; k <= int'(W_LEN) + 1; k++) begin
            chk($sformatf("wr_cs_n_k%0d", k), cs_n,
                (k <= int'(WRP) + 2 + (RB ? int'(RDW) : 0)) ? 0 : 1);
            chk($sformatf("wr_we_n_k%0d", k), we_n, (k >= 2 && k <= int'(WRP) + 1) ? 0 : 1);
            chk($sformatf("wr_oe_n_k%0d", k), oe_n,
                (RB && k > int'(WRP) + 2 && k <= int'(WRP) + 2 + int'(RDW)) ? 0 : 1);
            chk($sformatf("wr_ready_k%0d", k), req_ready, (k == int'(W_LEN) + 1) ? 1 : 0);
            if (k <= int'(W_LEN)) @(negedge clk);
        end

        // Single read of the same word with a strobe trace
        issue(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, w);
        for (int k = 1; k <= int'(RDW) + 2; k++) begin
            chk($sformatf("rd_cs_n_k%0d", k), cs_n, (k <= int'(RDW)) ? 0 : 1);
            chk($sformatf("rd_oe_n_k%0d", k), oe_n, (k <= int'(RDW)) ? 0 : 1);
            chk($sformatf("rd_we_n_k%0d", k), we_n, 1);
            chk($sformatf("rd_ready_k%0d", k), req_ready, (k == int'(RDW) + 2) ? 1 : 0);
            if (k <= int'(RDW) + 1) @(negedge clk);
        end
        drain();
        chk("rdata_hold", rsp_rdata, 16'hA5C3 & MASK);

        // Back-to-back requests with req_valid held high throughout
        issue(1'b1, 16'h0030, 16'h1234, 1'b1, 1'b1, w);
        issue(1'b0, 16'h0030, 16'h0000, 1'b1, 1'b1, w);
        chk("b2b_wait_after_wr", w, W_LEN);
        issue(1'b1, 16'h0031, 16'h00FF, 1'b1, 1'b1, w);
        chk("b2b_wait_after_rd", w, RDW + 1);
        issue(1'b0, 16'h0031, 16'h0000, 1'b0, 1'b1, w);
        chk("b2b_wait_after_wr2", w, W_LEN);
        drain();

        // Reset asserted in the middle of the write pulse
        issue(1'b1, 16'h0020, 16'h5A5A, 1'b0, 1'b0, w);
        @(negedge clk);
        chk("abort_in_pulse", we_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_we_n", we_n, 1);
        chk("abort_oe_n", oe_n, 1);
        chk("abort_bus", sram_io, 16'h0000);
        chk("abort_wr_done", wr_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        issue(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, w);
        chk("abort_next_wait", w, 0);
        drain();

        // Data patterns that exercise bit 0
        issue(1'b1, 16'h0040, 16'h0001, 1'b0, 1'b1, w);
        issue(1'b1, 16'h0041, 16'h0000, 1'b0, 1'b1, w);
        issue(1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, w);
        issue(1'b0, 16'h0041, 16'h0000, 1'b0, 1'b1, w);
        drain();

        // Random write/read pairs
        for (int i = 0; i < 6; i++) begin
            a = 16'h0050 + 16'($urandom_range(0, 15));
            d = 16'($urandom);
            issue(1'b1, a, d, 1'b0, 1'b1, w);
            issue(1'b0, a, 16'h0000, 1'b0, 1'b1, w);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
